// File: rtl/mem_responder.sv
// Single-port word RAM shared by the instruction-fetch and load/store ports.
// Data requests win arbitration; each access completes after WAIT wait states with a one-cycle ready.
module mem_responder #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam logic [2:0] WAIT_CNT = 3'(WAIT);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        port_q, port_d;     // 1 = data port, 0 = fetch port
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;

    logic        i_ready_q, i_ready_d;
    logic        i_err_q, i_err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        d_ready_q, d_ready_d;
    logic        d_err_q, d_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              fault;
    logic              commit;
    logic              mem_we;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (d_req || i_req) begin
                    port_d  = d_req;
                    addr_d  = d_req ? d_addr : i_addr;
                    we_d    = d_req & d_we;
                    wdata_d = d_wdata;
                    cnt_d   = WAIT_CNT;
                    state_d = (WAIT == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The *_d access fields equal the latched ones except on the accept edge,
    // which is also the commit edge when WAIT is zero.
    assign idx    = addr_d[ADDR_W+1:2];
    assign fault  = (|addr_d[1:0]) || (|addr_d[31:ADDR_W+2]);
    assign commit = (state_d == ST_RESP) && (state_q != ST_RESP);

    always_comb begin
        i_ready_d = 1'b0;
        i_err_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_ready_d = 1'b0;
        d_err_d   = 1'b0;
        d_rdata_d = d_rdata_q;
        mem_we    = 1'b0;
        if (commit) begin
            if (port_d) begin
                d_ready_d = 1'b1;
                d_err_d   = fault;
                if (fault)      d_rdata_d = 32'h0;
                else if (!we_d) d_rdata_d = mem[idx];
                else            mem_we    = reset;
            end else begin
                i_ready_d = 1'b1;
                i_err_d   = fault;
                i_rdata_d = fault ? 32'h0 : mem[idx];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            port_q    <= 1'b0;
            addr_q    <= 32'h0;
            we_q      <= 1'b0;
            wdata_q   <= 32'h0;
            i_ready_q <= 1'b0;
            i_err_q   <= 1'b0;
            i_rdata_q <= 32'h0;
            d_ready_q <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            port_q    <= port_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_ready_q <= i_ready_d;
            i_err_q   <= i_err_d;
            i_rdata_q <= i_rdata_d;
            d_ready_q <= d_ready_d;
            d_err_q   <= d_err_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // NOTE: the RAM array has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= wdata_d;
    end

    assign i_ready = i_ready_q;
    assign i_err   = i_err_q;
    assign i_rdata = i_rdata_q;
    assign d_ready = d_ready_q;
    assign d_err   = d_err_q;
    assign d_rdata = d_rdata_q;

endmodule
